// File: rtl/id_load_use_stall.sv
// Decode-stage load-use hazard controller: freezes PC and IF/ID, injects NOP bubbles into ID/EX,
// applies memory-stall freeze and branch-flush priority, and counts load-use events.
module id_load_use_stall #(
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       id_sr1,
    input  logic [2:0]       id_sr2,
    input  logic [2:0]       id_dest,
    input  logic             id_uses_sr1,
    input  logic             id_uses_sr2,
    input  logic             id_uses_dest,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic             ex_reg_write,
    input  logic [2:0]       ex_dest,
    input  logic             mem_stall,
    input  logic             br_flush,
    input  logic             clr_count,
    output logic             pc_load_en,
    output logic             if_id_load_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             stall_active,
    output logic [CNT_W-1:0] hazard_count
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    localparam logic [2:0] BUB_INIT = 3'(LOAD_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [2:0]       bub_cnt_r;
    logic [2:0]       bub_cnt_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             count_inc_s;
    logic             hz_s;

    assign hz_s = id_valid & ex_valid & ex_is_load & ex_reg_write &
                  ((id_uses_sr1  & (id_sr1  == ex_dest)) |
                   (id_uses_sr2  & (id_sr2  == ex_dest)) |
                   (id_uses_dest & (id_dest == ex_dest)));

    // Next-state and Mealy output decode; priority reset > mem_stall > br_flush > hazard/bubble
    always_comb begin
        state_nxt_s   = state_r;
        bub_cnt_nxt_s = bub_cnt_r;
        count_inc_s   = 1'b0;
        pc_load_en    = 1'b1;
        if_id_load_en = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        stall_active  = 1'b0;
        if (rst) begin
            pc_load_en    = 1'b0;
            if_id_load_en = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            stall_active  = 1'b0;
        end else if (mem_stall) begin
            // EX is frozen, so a visible hazard is stale and must not be acted on
            pc_load_en    = 1'b0;
            if_id_load_en = 1'b0;
            stall_active  = (state_r == BUBBLE);
        end else if (br_flush) begin
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            state_nxt_s   = RUN;
            bub_cnt_nxt_s = 3'd0;
        end else begin
            case (state_r)
                RUN: begin
                    if (hz_s) begin
                        pc_load_en    = 1'b0;
                        if_id_load_en = 1'b0;
                        id_ex_bubble  = 1'b1;
                        stall_active  = 1'b1;
                        count_inc_s   = 1'b1;
                        if (LOAD_BUBBLES > 1) begin
                            state_nxt_s   = BUBBLE;
                            bub_cnt_nxt_s = BUB_INIT;
                        end else begin
                            state_nxt_s   = RUN;
                            bub_cnt_nxt_s = 3'd0;
                        end
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                BUBBLE: begin
                    pc_load_en    = 1'b0;
                    if_id_load_en = 1'b0;
                    id_ex_bubble  = 1'b1;
                    stall_active  = 1'b1;
                    bub_cnt_nxt_s = bub_cnt_r - 3'd1;
                    if (bub_cnt_r <= 3'd1) begin
                        state_nxt_s   = RUN;
                        bub_cnt_nxt_s = 3'd0;
                    end else begin
                        state_nxt_s = BUBBLE;
                    end
                end
                default: begin
                    state_nxt_s   = RUN;
                    bub_cnt_nxt_s = 3'd0;
                end
            endcase
        end
    end

    // Saturating event counter; a clear in the same cycle wins over an increment
    always_comb begin
        if (clr_count) begin
            count_nxt_s = '0;
        end else if (count_inc_s && (count_r != CNT_MAX)) begin
            count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State, remaining-bubble and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= RUN;
            bub_cnt_r <= 3'd0;
            count_r   <= '0;
        end else begin
            state_r   <= state_nxt_s;
            bub_cnt_r <= bub_cnt_nxt_s;
            count_r   <= count_nxt_s;
        end
    end

    assign hazard_count = count_r;

endmodule
